sm_keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad on GPIO pins and debounces the result. It is the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column at a time, samples the four row lines and debounces whole-keypad scan frames. It reports one 4-bit key code with press strobe, held level and sticky ready flag.
- A 16-bit status word feeds GpioInput, so the CPU can poll and acknowledge keys through sm_matrix.

---
 rtl/sm_keypad_scanner.sv | 91 +++++++++
 tb/tb_sm_keypad_scanner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sm_keypad_scanner.sv
// sm_keypad_scanner: 4x4 keypad column scanner with frame-level debounce, key code, strobe and sticky ready flag
module sm_keypad_scanner #(
  parameter int SCAN_DIV = 256,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  input  logic        key_ack,
  output logic [3:0]  key_code,
  output logic        key_pressed,
  output logic        key_strobe,
  output logic        key_ready,
  output logic [15:0] status
);
  typedef enum logic [1:0] {NONE, KEY, MULTI} res_t;
  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
  logic [3:0] rows_m, rows_s;
  logic [1:0] col_idx, hits, tot, low_row;
  logic [15:0] cnt;
  logic [3:0] hit_code, acc_code, frame_code, cand_code, dcnt, nxt_cnt, tot_sum;
  logic [2:0] row_sum;
  logic sample, frame_done, same, acc_press, acc_rel;
  res_t frame_res, cand;
  always_comb begin
    sample = cnt == LAST;
    row_sum = 3'(rows_s[0]) + 3'(rows_s[1]) + 3'(rows_s[2]) + 3'(rows_s[3]);
    tot_sum = {2'b0, hits} + {1'b0, row_sum};
    tot = tot_sum >= 4'd2 ? 2'd2 : tot_sum[1:0];
    low_row = rows_s[0] ? 2'd0 : rows_s[1] ? 2'd1 : rows_s[2] ? 2'd2 : 2'd3;
    // columns are visited in ascending order, so the first hit of a frame is the lowest code
    acc_code = (hits == 2'd0 && row_sum != 3'd0) ? {col_idx, low_row} : hit_code;
    same = frame_res == cand && (frame_res != KEY || frame_code == cand_code);
    nxt_cnt = !same ? 4'd1 : dcnt == DF ? dcnt : dcnt + 4'd1;
    acc_press = frame_done && frame_res == KEY && nxt_cnt == DF && (!key_pressed || key_code != frame_code);
    acc_rel = frame_done && frame_res == NONE && nxt_cnt == DF && key_pressed;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_m <= '0;
      rows_s <= '0;
      cnt <= '0;
      col_idx <= '0;
      hits <= '0;
      hit_code <= '0;
      frame_done <= 1'b0;
      frame_res <= NONE;
      frame_code <= '0;
      cand <= NONE;
      cand_code <= '0;
      dcnt <= '0;
      key_code <= '0;
      key_pressed <= 1'b0;
      key_strobe <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
      cnt <= sample ? 16'd0 : cnt + 16'd1;
      frame_done <= sample && col_idx == 2'd3;
      if (sample) begin
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          frame_res <= tot == 2'd0 ? NONE : tot == 2'd1 ? KEY : MULTI;
          frame_code <= acc_code;
          hits <= '0;
          hit_code <= '0;
        end else begin
          hits <= tot;
          hit_code <= acc_code;
        end
      end
      if (frame_done) begin
        cand <= frame_res;
        cand_code <= frame_code;
        dcnt <= nxt_cnt;
      end
      key_strobe <= acc_press;
      if (acc_press) begin
        key_code <= frame_code;
        key_pressed <= 1'b1;
      end else if (acc_rel)
        key_pressed <= 1'b0;
      key_ready <= acc_press | (key_ready & ~key_ack);
    end
  end
  assign cols = 4'b0001 << col_idx;
  assign status = {key_ready, key_pressed, 10'b0, key_code};
endmodule

// File: tb/tb_sm_keypad_scanner.sv
// tb_sm_keypad_scanner: directed checks of scan, debounce, ack and reset with an emulated key matrix
module tb_sm_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic key_ack = 1'b0;
  logic [3:0] key_code;
  logic key_pressed, key_strobe, key_ready;
  logic [15:0] status;
  logic [15:0] keys = '0;
  int checks = 0;
  int failures = 0;
  int ec = 0;
  int n_strobe = 0;

  sm_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .key_ack(key_ack),
    .key_code(key_code), .key_pressed(key_pressed), .key_strobe(key_strobe),
    .key_ready(key_ready), .status(status)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (cols[c] && keys[c*4+r]) rows[r] = 1'b1;
  end

  always @(negedge clk) if (key_strobe === 1'b1) n_strobe <= n_strobe + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  task automatic step_to(input int n);
    while (ec < n) begin
      @(posedge clk);
      ec++;
    end
    #1;
  endtask

  initial begin
    keys = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cols", 16'(cols), 16'h1);
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_flags", {13'b0, key_pressed, key_strobe, key_ready}, 16'h0);
    chk("rst_status", status, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ec = 0;
    step_to(48);
    chk("press_early", {15'b0, key_strobe}, 16'h0);
    chk("press_early_held", {15'b0, key_pressed}, 16'h0);
    step_to(49);
    chk("press_strobe", {15'b0, key_strobe}, 16'h1);
    chk("press_status", status, 16'hC009);
    step_to(50);
    chk("strobe_one_cycle", {15'b0, key_strobe}, 16'h0);
    step_to(81);
    chk("no_refire", 16'(n_strobe), 16'd1);
    keys = '0;
    step_to(128);
    chk("release_early", {15'b0, key_pressed}, 16'h1);
    step_to(129);
    chk("release_status", status, 16'h8009);
    chk("release_no_strobe", {15'b0, key_strobe}, 16'h0);
    keys = 16'h0200;
    key_ack = 1'b1;
    step_to(130);
    key_ack = 1'b0;
    chk("ack_clears", status, 16'h0009);
    for (int n = 10; n <= 15; n++) begin
      step_to(16*(n-1)+1);
      keys = (n % 2 == 1) ? 16'h0200 : 16'h0000;
    end
    step_to(272);
    chk("bounce_no_strobe", 16'(n_strobe), 16'd1);
    chk("bounce_not_held", {15'b0, key_pressed}, 16'h0);
    key_ack = 1'b1;
    step_to(273);
    key_ack = 1'b0;
    chk("steady_strobe", {15'b0, key_strobe}, 16'h1);
    chk("ack_vs_set", status, 16'hC009);
    keys = 16'h0041;
    step_to(433);
    chk("multi_no_strobe", 16'(n_strobe), 16'd2);
    chk("multi_keeps", status, 16'hC009);
    keys = 16'h0001;
    step_to(480);
    chk("single_early", {15'b0, key_strobe}, 16'h0);
    step_to(481);
    chk("single_strobe", {15'b0, key_strobe}, 16'h1);
    chk("single_status", status, 16'hC000);
    keys = 16'h0200;
    key_ack = 1'b1;
    step_to(482);
    key_ack = 1'b0;
    chk("ack2_clears", status, 16'h4000);
    chk("strobe_total", 16'(n_strobe), 16'd3);
    key_ack = 1'b1;
    step_to(483);
    key_ack = 1'b0;
    chk("ack_noop", status, 16'h4000);
    step_to(520);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cols", 16'(cols), 16'h1);
    chk("async_rst_status", status, 16'h0);
    chk("async_rst_strobe", {15'b0, key_strobe}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ec = 0;
    step_to(48);
    chk("post_rst_early", {15'b0, key_strobe}, 16'h0);
    chk("post_rst_early_st", status, 16'h0);
    step_to(49);
    chk("post_rst_strobe", {15'b0, key_strobe}, 16'h1);
    chk("post_rst_status", status, 16'hC009);
    step_to(50);
    chk("post_rst_total", 16'(n_strobe), 16'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
